// File: rtl/hydro_axis_tx.sv
// Hydrophone 4x16-bit sample-set framer: buffers frames in a small FIFO
// and sends each one as two 32-bit AXI-Stream beats.
module hydro_axis_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [15:0]                   ch1,
  input  logic [15:0]                   ch2,
  input  logic [15:0]                   ch3,
  input  logic [15:0]                   ch4,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_WIDTH-1:0]         drop_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic BEAT0 = 1'b0;
  localparam logic BEAT1 = 1'b1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  phase_q, phase_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic [63:0]           mem_q [FIFO_DEPTH];
  logic [63:0]           mem_d [FIFO_DEPTH];

  logic        empty;
  logic        full;
  logic        hs;
  logic        pop;
  logic        strobe;
  logic        push;
  logic        drop;
  logic [63:0] head;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign hs     = m_axis_tvalid && m_axis_tready;
  assign pop    = hs && (phase_q == BEAT1);
  assign strobe = enable && sample_valid;
  assign push   = strobe && (!full || pop);
  assign drop   = strobe && full && !pop;
  assign head   = mem_q[rd_ptr_q];

  assign m_axis_tvalid = !empty;
  assign m_axis_tlast  = !empty && (phase_q == BEAT1);
  assign fifo_level    = level_q;
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;

  always_comb begin
    m_axis_tdata = '0;
    if (!empty) begin
      m_axis_tdata = (phase_q == BEAT1) ? head[63:32] : head[31:0];
    end
  end

  // When full, a push only happens alongside a pop, so it lands in
  // the slot the head vacates on that same edge.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {ch4, ch3, ch2, ch1};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    phase_d  = phase_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    if (hs) begin
      phase_d = ~phase_q;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (!(&drop_q)) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= BEAT0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule
